// File: rtl/tristate_bus_pkg.sv
// tristate_bus_pkg: shared reader FSM state type and sizing helpers
package tristate_bus_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {IDLE, SETTLE, CAPTURE, WAIT_RELEASE} state_t;
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/bus_sync_fifo.sv
// bus_sync_fifo: synchronous FIFO; a push on full is accepted only when a pop frees a slot the same cycle
module bus_sync_fifo import tristate_bus_pkg::*; #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                din,
    output logic [W-1:0]                dout,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign empty = level == '0;
    assign full = level == LW'(DEPTH);
    assign pop_ok = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (push_ok && !reset) mem[wr_ptr] <= din;
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
endmodule

// File: rtl/tristate_bus_reader.sv
// tristate_bus_reader: captures one settled word per bus_en window into a FIFO; BUS_PARITY_EN adds parity check
module tristate_bus_reader import tristate_bus_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bus_en,
    input  logic [WIDTH-1:0]            bus_data,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic [level_w(DEPTH)-1:0]   fifo_level,
    output logic                        busy
`ifdef BUS_PARITY_EN
    ,
    input  logic                        bus_parity,
    output logic                        out_err
`endif
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
`ifdef BUS_PARITY_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [WIDTH-1:0] data_q;
    logic bus_en_s, push, full, empty;
    logic [FW-1:0] din, dout;
    assign bus_en_s = sync[SYNC_STAGES-1];
    assign out_data = dout[WIDTH-1:0];
    assign out_valid = !empty;
    assign busy = state != IDLE;
`ifdef BUS_PARITY_EN
    logic par_q;
    // stored bit is 1 when {data, parity} has odd weight, i.e. even parity failed
    assign din = {^{data_q, par_q}, data_q};
    assign out_err = dout[WIDTH];
    always_ff @(posedge clk)
        if (reset) par_q <= 1'b0;
        else par_q <= bus_parity;
`else
    assign din = data_q;
`endif
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            sync <= '0;
            data_q <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sync <= {sync[SYNC_STAGES-2:0], bus_en};
            data_q <= bus_data;
            if (push && full && !out_ready) overflow <= 1'b1;
        end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        push = 1'b0;
        case (state)
            IDLE: if (bus_en_s) begin
                state_n = SETTLE;
                cnt_n = '0;
            end
            SETTLE:
                if (!bus_en_s) state_n = IDLE;
                else if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = CAPTURE;
                else cnt_n = cnt + 1'b1;
            CAPTURE: begin
                push = 1'b1;
                state_n = WAIT_RELEASE;
            end
            WAIT_RELEASE: if (!bus_en_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    bus_sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(out_ready),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
endmodule
